// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the RV64 load/store port.
// A request is accepted in IDLE, held for a fixed latency in WAIT, accessed on
// the last WAIT edge, then presented in RESP until the consumer takes it.
module data_mem_responder #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_write;
  logic [63:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [2:0]      r_funct3;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [63:0]     r_resp_rdata;
  logic            r_resp_err;

  logic [7:0]      r_mem [DEPTH_BYTES];

  logic [3:0]      w_size;
  logic            w_mis;
  logic            w_oor;
  logic            w_ill;
  logic            w_err;
  logic [64:0]     w_end;
  logic [AW-1:0]   w_idx;
  logic [63:0]     w_raw;
  logic [63:0]     w_ld;
  logic            w_access;

  assign w_size   = 4'd1 << r_funct3[1:0];
  // Size is a power of two, so alignment only looks at the low three bits.
  assign w_mis    = (r_addr[2:0] & (w_size[2:0] - 3'd1)) != 3'd0;
  // Last byte computed in 65 bits so addresses near 2^64 cannot wrap into range.
  assign w_end    = {1'b0, r_addr} + 65'(w_size) - 65'd1;
  assign w_oor    = w_end >= 65'(DEPTH_BYTES);
  assign w_ill    = r_write ? r_funct3[2] : (r_funct3 == 3'b111);
  assign w_err    = w_mis | w_oor | w_ill;
  assign w_idx    = r_addr[AW-1:0];
  assign w_access = (r_state == S_WAIT) && (r_cnt == '0);

  // Gather the addressed bytes little-endian; unused upper bytes stay zero.
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < 8; i++) begin
      if (!w_err && (i < int'(w_size)))
        w_raw[8*i +: 8] = r_mem[w_idx + AW'(i)];
    end
  end

  // Sign-extend signed loads; unsigned and double loads pass the zero-filled bytes.
  always_comb begin
    case (r_funct3)
      3'b000:  w_ld = {{56{w_raw[7]}},  w_raw[7:0]};
      3'b001:  w_ld = {{48{w_raw[15]}}, w_raw[15:0]};
      3'b010:  w_ld = {{32{w_raw[31]}}, w_raw[31:0]};
      default: w_ld = w_raw;
    endcase
  end

  // Store bytes on the access edge only; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_access && r_write && !w_err) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(w_size))
          r_mem[w_idx + AW'(i)] <= r_wdata[8*i +: 8];
      end
    end
  end

  // Request/latency/response FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_funct3    <= req_funct3;
            r_cnt       <= CW'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rdata <= (w_err || r_write) ? 64'd0 : w_ld;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          // A request presented alongside resp_ready waits for the next IDLE cycle.
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor's load/store port: accepts one request at a time over a valid/ready handshake, waits a fixed latency, then returns a response over a second valid/ready handshake.
- Performs RV64 byte, half, word and double accesses, little-endian, with sign or zero extension on loads.
- Sits behind the EX_MEM stage as the multi-cycle replacement for the single-cycle data memory.
- Flags misaligned, out-of-range and illegal-funct3 accesses.

Parameters:
- DEPTH_BYTES, 256: memory size in bytes; must be a multiple of 8.
- LATENCY, 2: cycles from request acceptance to the access edge; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data; low bytes are used according to size.
- req_funct3  input  3  RV64 load/store funct3.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  64  load result, extended; 0 for stores and errors.
- resp_err  output  1  access faulted.

Behaviour:
- Reset values while reset=0:
  - State = IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Latched request fields and counter cleared.
  - Memory array contents are not reset; the bench writes before it reads.
- FSM state IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch write, addr, wdata and funct3, load cnt=LATENCY-1, and go to WAIT.
- FSM state WAIT:
  - req_ready=0.
  - If cnt≠0, decrement cnt.
  - If cnt=0, perform the access on this edge and go to RESP.
  - Net effect: a request accepted at edge T0 is accessed at edge T0+LATENCY.
- FSM state RESP:
  - resp_valid=1; resp_rdata and resp_err are registered and held stable while resp_ready=0.
  - On an edge with resp_ready=1, go to IDLE and drop resp_valid.
  - Throughput: one transaction per LATENCY+2 cycles at best.
  - No request is accepted in WAIT or RESP; req_valid there is ignored and the requester must hold it.
- Size decoding from funct3[1:0]:
  - 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 8 bytes.
- Loads:
  - 000 lb, 001 lh, 010 lw, 011 ld sign-extend to 64 bits.
  - 100 lbu, 101 lhu, 110 lwu zero-extend to 64 bits.
  - 111 is illegal.
- Stores:
  - funct3[2] must be 0; funct3[2]=1 is illegal.
  - Write the low size bytes of wdata at addr..addr+size-1, little-endian; other bytes are untouched.
- Error conditions (any one sets resp_err=1):
  - addr not a multiple of size (misaligned).
  - addr+size-1 ≥ DEPTH_BYTES, evaluated without 64-bit wrap (addr ≥ DEPTH_BYTES is an error).
  - Illegal funct3.
- On error: no memory write occurs and resp_rdata=0.
- Store response: resp_valid=1 with resp_rdata=0 and resp_err reflecting the checks.
- A load following a store to the same bytes returns the new data, because accesses are strictly serialized.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and the transaction is abandoned with no response.
  - A store whose access edge has not occurred is not written.
  - A store already performed remains in memory.
- Simultaneous req_valid and resp_ready in RESP: only the response handshake completes; the request is taken in the following IDLE cycle.

Test Plan:
- Reset, LATENCY=2: release reset, send sd addr=0x10 wdata=0x8877665544332211 at edge 0. Required: req_ready=0 after edge 0; resp_valid=1 after edge 2, resp_err=0, resp_rdata=0; resp_ready=1 at edge 3 makes req_ready=1.
- Loads after that store: lb 0x17 → 0xFFFFFFFFFFFFFF88; lbu 0x17 → 0x88; lh 0x12 → 0x4433; lw 0x14 → 0xFFFFFFFF88776655; ld 0x10 → 0x8877665544332211.
- Partial store: sb 0x11 wdata=0xAB, then ld 0x10 → 0x887766554433AB11. Repeat with sh 0x16 wdata=0xCAFE and confirm only bytes 0x16–0x17 change.
- Errors, each giving resp_err=1 and resp_rdata=0 with memory unchanged (checked by ld 0x10): lw 0x12, ld 0x100, funct3=111 load, store with funct3=100.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises. Required: resp_valid and resp_rdata stable; req_valid pulses ignored; req_ready=0 throughout.
- Reset mid-op: send sd 0x20 wdata=0x1, assert reset one cycle after accept (before the access edge), then release. Required: outputs at reset values, no response; ld 0x20 returns prior contents. Repeat with LATENCY=1.
